// File: rtl/dmem_bytelane_bcd.sv
// Byte-addressable RV32 data memory with RV32I load/store widths,
// access-fault detection and a double-dabble BCD display mirror.
module dmem_bytelane_bcd #(
    parameter int DM_ADDRESS  = 11,
    parameter int DATA_W      = 32,
    parameter int DISP_WORD   = 11,
    parameter int DISP_DIGITS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     MemRead,
    input  logic                     MemWrite,
    input  logic [2:0]               funct3,
    input  logic [DM_ADDRESS-1:0]    a,
    input  logic [DATA_W-1:0]        wd,
    output logic [DATA_W-1:0]        rd,
    output logic                     access_fault,
    output logic [4*DISP_DIGITS-1:0] disp_bcd,
    output logic                     disp_valid,
    output logic                     disp_busy
);
    localparam int WA = DM_ADDRESS - 2;
    localparam int NW = 2 ** WA;
    localparam int CW = $clog2(DATA_W);
    localparam int BW = 4 * DISP_DIGITS;

    typedef enum logic {IDLE, CONV} state_t;

    logic [DATA_W-1:0] mem [NW];
    logic [WA-1:0]     widx;
    logic [1:0]        lane;
    logic [DATA_W-1:0] wrd;
    logic [7:0]        bsel;
    logic [15:0]       hsel;
    logic [3:0]        wmask;
    logic [DATA_W-1:0] wdat;
    logic [DATA_W-1:0] merged;
    logic              we;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [DATA_W-1:0] bin_q, bin_n;
    logic [39:0]       acc, acc_n, adj;
    logic [BW-1:0]     bcd_n;
    logic              valid_n;

    assign widx = a[DM_ADDRESS-1:2];
    assign lane = a[1:0];
    assign wrd  = mem[widx];
    assign bsel = wrd[8*lane +: 8];
    assign hsel = lane[1] ? wrd[31:16] : wrd[15:0];

    // Fault decode: illegal width, misalignment, or unsigned store code
    always_comb begin
        access_fault = 1'b0;
        if (MemRead || MemWrite) begin
            unique case (1'b1)
                funct3 == 3'b011,
                funct3[2:1] == 2'b11:
                    access_fault = 1'b1;
                funct3[1:0] == 2'b01:
                    access_fault = lane[0] ||
                        (MemWrite && funct3[2]);
                funct3 == 3'b010:
                    access_fault = (lane != 2'b00);
                default:
                    access_fault = MemWrite && funct3[2];
            endcase
        end
    end

    // Load path: lane select plus sign/zero extension, zero when idle
    always_comb begin
        rd = '0;
        if (MemRead && !access_fault) begin
            case (funct3)
                3'b000:  rd = {{(DATA_W-8){bsel[7]}}, bsel};
                3'b100:  rd = {{(DATA_W-8){1'b0}}, bsel};
                3'b001:  rd = {{(DATA_W-16){hsel[15]}}, hsel};
                3'b101:  rd = {{(DATA_W-16){1'b0}}, hsel};
                3'b010:  rd = wrd;
                default: rd = '0;
            endcase
        end
    end

    // Store lane mask and replicated data, merged over the current word
    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                wmask = 4'b0001 << lane;
                wdat  = {4{wd[7:0]}};
            end
            2'b01: begin
                wmask = lane[1] ? 4'b1100 : 4'b0011;
                wdat  = {2{wd[15:0]}};
            end
            default: begin
                wmask = 4'b1111;
                wdat  = wd;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = wmask[i] ? wdat[8*i +: 8]
                                        : wrd[8*i +: 8];
        end
    end

    assign we = MemWrite && !access_fault;

    // Memory array write; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (we) mem[widx] <= merged;
    end

    // Display mirror state and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bin_q      <= '0;
            acc        <= '0;
            disp_bcd   <= '0;
            disp_valid <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bin_q      <= bin_n;
            acc        <= acc_n;
            disp_bcd   <= bcd_n;
            disp_valid <= valid_n;
        end
    end

    // Double-dabble step; a store to the mirrored word (re)starts it
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bin_n   = bin_q;
        acc_n   = acc;
        bcd_n   = disp_bcd;
        valid_n = disp_valid;
        for (int i = 0; i < 10; i++) begin
            adj[4*i +: 4] = (acc[4*i +: 4] >= 4'd5)
                ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
        end
        if (we && widx == WA'(DISP_WORD)) begin
            bin_n   = merged;
            acc_n   = '0;
            cnt_n   = '0;
            state_n = CONV;
        end else if (state == CONV) begin
            {acc_n, bin_n} = {adj, bin_q} << 1;
            cnt_n = cnt + 1'b1;
            if (cnt == CW'(DATA_W - 1)) begin
                bcd_n   = acc_n[BW-1:0];
                valid_n = 1'b1;
                state_n = IDLE;
            end
        end
    end

    assign disp_busy = (state == CONV);

endmodule

// File: doc/dmem_bytelane_bcd.md
# dmem_bytelane_bcd

Byte-addressable RV32 data memory for the single-cycle core. It replaces the word-only data memory and sits on the ALU-result / rs2 datapath, with the load result feeding the writeback mux. It supports all RV32I load/store widths and flags misaligned or illegal accesses. A sequential double-dabble converter continuously mirrors one configurable memory word onto BCD digits for the board's seven-segment displays.

## Interface
Parameters:
- DM_ADDRESS, 11: byte-address width. The array holds 2**(DM_ADDRESS-2) words.
- DATA_W, 32: word width. Fixed at 32 for RV32; must be a multiple of 8 and ≤ 32.
- DISP_WORD, 11: word index mirrored to the display.
- DISP_DIGITS, 4: number of BCD digits exported, 1..10.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- MemRead  in  1  load enable (level).
- MemWrite  in  1  store enable, sampled at the rising edge of clk.
- funct3  in  3  RV32I width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- a  in  DM_ADDRESS  byte address (LSBs of the ALU result).
- wd  in  DATA_W  store data; the low bytes are used for SB/SH.
- rd  out  DATA_W  load data, extended per funct3.
- access_fault  out  1  misaligned access or illegal funct3.
- disp_bcd  out  4*DISP_DIGITS  BCD of the mirrored word mod 10^DISP_DIGITS; digit 0 is in the LSBs.
- disp_valid  out  1  disp_bcd holds a completed conversion.
- disp_busy  out  1  conversion in progress.

## Operation
- Word index = a[DM_ADDRESS-1:2]. Byte lane = a[1:0].
- Fault conditions (combinational), evaluated only when MemRead or MemWrite is high:
  - funct3 ∈ {011, 110, 111}.
  - Half access with a[0]=1.
  - Word access with a[1:0]≠0.
  - A store with funct3 100 or 101.
- Load (MemRead=1, no fault), combinational:
  - LB/LBU select byte a[1:0].
  - LH/LHU select half a[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- rd = 0 when MemRead=0 or on a fault. rd never holds a stale value, so no latch is inferred.
- Store (MemWrite=1, no fault):
  - At posedge, only the addressed byte lanes of the word are written. Other lanes keep their value.
  - A faulting store writes nothing.
- The memory array is not reset; its contents are undefined until written.
- Display mirror FSM states:
  - IDLE: on a posedge committing a non-faulting store to word DISP_WORD:
    - load bin_q with the merged post-write word;
    - clear the 40-bit BCD accumulator and cnt;
    - go to CONV.
  - CONV: each posedge:
    - add 3 to every accumulator digit ≥ 5;
    - shift {acc, bin_q} left by 1;
    - cnt++.
  - On the shift where cnt = DATA_W-1, load disp_bcd from the low 4*DISP_DIGITS accumulator bits, set disp_valid=1, and return to IDLE.
- The value is treated as unsigned DATA_W bits.
- A qualifying store during CONV aborts and restarts the conversion with the new word. disp_bcd keeps its previous value until the restarted conversion completes.
- Stores to other words, and loads, do not affect the FSM.

## Timing
- Reset (async assert, sync-safe deassert):
  - state=IDLE, cnt=0, bin_q=0, accumulator=0;
  - disp_bcd=0, disp_valid=0, disp_busy=0.
  - rd and access_fault are combinational and follow their inputs during reset.
- Load latency: 0 cycles, combinational from a, funct3, MemRead and the array.
- A store is visible to a load from the cycle after its commit edge.
- Conversion timing, with the commit at edge E:
  - disp_busy=1 after E.
  - disp_bcd and disp_valid update at edge E+DATA_W, i.e. 32 cycles.
  - disp_busy=0 after E+DATA_W.
- A restart at edge R moves completion to R+DATA_W.
- Reset mid-conversion: the conversion is abandoned and outputs return to their reset values.

## Test plan
- SW 0x8000_00F0 to a=0x010; then LB, LBU, LH, LHU, LW at a=0x010 → rd = 0xFFFF_FFF0, 0x0000_00F0, 0x0000_00F0, 0x0000_00F0, 0x8000_00F0.
- SW 0x1122_3344 to a=0x020, then SB 0xAA to a=0x023 → LW gives 0xAA22_3344. Then SH 0xBBCC to a=0x020 → LW gives 0xAA22_BBCC.
- LW at a=0x022, SH at a=0x021, and funct3=011 → access_fault=1, rd=0, memory unchanged on a re-read.
- SW 1234 to word 11 (a=0x02C) → disp_busy for 32 cycles, then disp_bcd=0x1234 and disp_valid=1. SW 0xFFFF_FFFF → disp_bcd=0x7295 (4294967295 mod 10^4).
- SW 99 to word 11, then SW 7 to the same word 10 cycles later → disp_bcd stays at its prior value until 32 cycles after the second store, then reads 0x0007.
- Assert rst_n=0 at cycle 16 of a conversion → disp_valid=0, disp_bcd=0, disp_busy=0 immediately. Memory contents are retained.
